// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//
// Purpose
//   Pipelined add/subtract unit for the datapath ALU, with ARM-style NZCV flags.
//   The WIDTH-bit operation is cut into STAGES equal slices of SLICE bits.
//   Stage k adds slice k of the operands plus the carry registered by stage k-1.
//   Slices that are already finished travel down the pipe alongside the
//   operands. The last stage doubles as the output register.
//   The unit accepts one operation per cycle while the consumer keeps up.
//
// Parameters
//   WIDTH   operand/result width; WIDTH % STAGES must be 0
//   STAGES  pipeline depth = number of slices, 1 <= STAGES <= WIDTH
//
// Configuration
//   PIPE_ADDER_FLAGS_EN  when defined, NZCV flags are computed and registered.
//                        When undefined, flags is tied to 4'b0000. Sum,
//                        handshake and latency are the same in both builds.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   in_valid   in   1      operands/op present
//   in_ready   out  1      unit accepts this cycle (= global advance)
//   a, b       in   WIDTH  operands
//   op         in   2      00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin        in   1      carry in (ADC/SBC only)
//   out_valid  out  1      result present
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   flags      out  4      {N,Z,C,V}
// -----------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [3:0]       flags
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
            $error("pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    // The whole pipe moves as one unit. A bubble still occupies its slot;
    // slots are never collapsed. This keeps latency fixed at STAGES cycles
    // while the consumer keeps up.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1. SBC/ADC take the carry from cin instead.
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff = op[0] ? ~b : b;
    assign c0    = op[1] ? cin : op[0];

    // src_* is the view each stage's adder sees. Stage 0 sees the
    // conditioned inputs. Stage k > 0 sees the register of stage k-1.
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];

    logic [WIDTH-1:0] s_nxt [STAGES];
    logic             c_nxt [STAGES];

    assign src_a[0] = a;
    assign src_b[0] = b_eff;
    assign src_s[0] = '0;
    assign src_c[0] = c0;
    assign src_v[0] = in_valid;

    // Per-stage slice adder. Partial sums keep every slice above the
    // current one at zero. Slice k can therefore be OR-ed into place.
    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_slice
            logic [SLICE:0] part;
            assign part = {1'b0, src_a[k][k*SLICE +: SLICE]}
                        + {1'b0, src_b[k][k*SLICE +: SLICE]}
                        + {{SLICE{1'b0}}, src_c[k]};
            assign c_nxt[k] = part[SLICE];
            assign s_nxt[k] = src_s[k] | (WIDTH'(part[SLICE-1:0]) << (k*SLICE));
        end
    endgenerate

    // Intermediate stages 0..STAGES-2. Data registers have no reset. Their
    // contents only matter when the matching vld_p bit is set.
    generate
        if (STAGES > 1) begin : g_mid
            logic [WIDTH-1:0] a_p   [LAST];
            logic [WIDTH-1:0] b_p   [LAST];
            logic [WIDTH-1:0] s_p   [LAST];
            logic             c_p   [LAST];
            logic             vld_p [LAST];

            always_ff @(posedge clk) begin
                if (adv) begin
                    for (int k = 0; k < LAST; k++) begin
                        a_p[k] <= src_a[k];
                        b_p[k] <= src_b[k];
                        s_p[k] <= s_nxt[k];
                        c_p[k] <= c_nxt[k];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < LAST; k++) begin
                        vld_p[k] <= 1'b0;
                    end
                end else if (adv) begin
                    for (int k = 0; k < LAST; k++) begin
                        vld_p[k] <= src_v[k];
                    end
                end
            end

            // ---- stage boundary: register k feeds adder k+1 ----
            for (genvar k = 0; k < LAST; k++) begin : g_link
                assign src_a[k+1] = a_p[k];
                assign src_b[k+1] = b_p[k];
                assign src_s[k+1] = s_p[k];
                assign src_c[k+1] = c_p[k];
                assign src_v[k+1] = vld_p[k];
            end
        end
    endgenerate

    // ---- final stage: output register ----
    // sum only loads when a valid result arrives. The last result therefore
    // stays on the port after it drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else if (adv) begin
            out_valid <= src_v[LAST];
            if (src_v[LAST]) begin
                sum <= s_nxt[LAST];
            end
        end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    // V = carry-in(MSB) ^ carry-out(MSB). This equals "both addend MSBs
    // agree and the result MSB differs". The comparison form needs no
    // extra carry tap inside the last slice.
    function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] s,
                                        input logic             a_msb,
                                        input logic             b_msb,
                                        input logic             c_out);
        logic n;
        logic z;
        logic v;
        n = s[WIDTH-1];
        z = (s == '0);
        v = (a_msb == b_msb) && (n != a_msb);
        return {n, z, c_out, v};
    endfunction

    logic [3:0] flags_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r <= 4'b0000;
        end else if (adv && src_v[LAST]) begin
            flags_r <= nzcv(s_nxt[LAST], src_a[LAST][WIDTH-1],
                            src_b[LAST][WIDTH-1], c_nxt[LAST]);
        end
    end

    assign flags = flags_r;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    localparam int W = 64;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flags     (flags)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef PIPE_ADDER_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    // One isolated operation, out_ready=1. Checks latency, sum and flags.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic c, input logic [63:0] es,
                          input logic [3:0] ef);
        int lat;
        @(negedge clk);
        op        = o;
        a         = x;
        b         = y;
        cin       = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(S));
        check_val({tag, "_sum"}, sum, es);
        check_val({tag, "_flags"}, 64'(flags), 64'(exp_flags(ef)));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] pat;
    logic [63:0] prev_sum;
    logic [3:0]  prev_flags;
    logic        held_prev;
    logic        exp_rdy;
    int          cyc;
    int          sent;
    int          got;
    int          seen;

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        cin       = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_sum", sum, 64'd0);
        check_val("rst_flags", 64'(flags), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors: carries across slices, subtraction, overflow
        run_op("add_wrap",  2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0110);
        run_op("add_xslice", 2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
               64'h0000_0001_0000_0000, 4'b0000);
        run_op("add_hi", 2'b00, 64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
               64'd0, 4'b0110);
        run_op("sub_neg", 2'b01, 64'd5, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        run_op("sub_pos", 2'b01, 64'd7, 64'd5, 1'b0, 64'd2, 4'b0010);
        run_op("sub_zero", 2'b01, 64'd0, 64'd0, 1'b0, 64'd0, 4'b0110);
        run_op("add_ovf", 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 4'b1001);
        run_op("sbc_c0", 2'b11, 64'd10, 64'd3, 1'b0, 64'd6, 4'b0010);
        run_op("sbc_c1", 2'b11, 64'd10, 64'd3, 1'b1, 64'd7, 4'b0010);
        run_op("adc_c1", 2'b10, 64'd1, 64'd2, 1'b1, 64'd4, 4'b0000);
        run_op("add_cin_ignored", 2'b00, 64'd1, 64'd2, 1'b1, 64'd3, 4'b0000);
        run_op("sub_cin_ignored", 2'b01, 64'd9, 64'd4, 1'b0, 64'd5, 4'b0010);

        // Back-to-back ADDs i+i with a stalling consumer
        pat       = 16'b1100_1110_0101_1001;
        cyc       = 0;
        sent      = 0;
        got       = 0;
        held_prev = 1'b0;
        prev_sum  = '0;
        prev_flags = '0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            if (held_prev) begin
                check_val("hold_out_valid", 64'(out_valid), 64'd1);
                check_val("hold_sum", sum, prev_sum);
                check_val("hold_flags", 64'(flags), 64'(prev_flags));
            end
            out_ready = pat[cyc % 16];
            in_valid  = (sent < 8);
            op        = 2'b00;
            cin       = 1'b0;
            a         = 64'(sent + 1);
            b         = 64'(sent + 1);
            #1;
            exp_rdy = !out_valid || out_ready;
            check_val("b2b_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid && out_ready) begin
                check_val("b2b_sum", sum, 64'(2 * (got + 1)));
                check_val("b2b_flags", 64'(flags), 64'd0);
                got++;
            end
            held_prev  = out_valid && !out_ready;
            prev_sum   = sum;
            prev_flags = flags;
            @(posedge clk);
            if (in_valid && exp_rdy) sent++;
            cyc++;
        end
        check_val("b2b_sent", 64'(sent), 64'd8);
        check_val("b2b_got", 64'(got), 64'd8);

        // No duplicates after the stream, and the last result stays on the port
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("b2b_no_extra", 64'(seen), 64'd0);
        check_val("b2b_sum_kept", sum, 64'd16);

        // Reset with operations in flight
        @(negedge clk);
        out_ready = 1'b1;
        op        = 2'b00;
        cin       = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = 64'(i);
            b = 64'(i);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("inflight_out_valid", 64'(out_valid), 64'd1);
        check_val("inflight_sum", sum, 64'd2);
        #1 reset_n = 1'b0;
        #1;
        check_val("async_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_sum", sum, 64'd0);
        check_val("async_rst_flags", 64'(flags), 64'd0);
        #1 reset_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("no_stale_after_rst", 64'(seen), 64'd0);
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
        run_op("post_rst_add", 2'b00, 64'h10, 64'h20, 1'b0, 64'h30, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
